// File: rtl/cross_bar_nxm_pkg.sv
// cross_bar_nxm_pkg: command encoding, default sizing and the round-robin pick helper
// shared by the crossbar top and its per-slave ID FIFO.
package cross_bar_nxm_pkg;

    typedef enum logic {
        CMD_RD = 1'b0,
        CMD_WR = 1'b1
    } cmd_e;

    localparam int N_MASTERS_DEF = 4;
    localparam int N_SLAVES_DEF  = 4;
    localparam int RD_DEPTH_DEF  = 4;
    localparam int SEL_W         = $clog2(N_SLAVES_DEF);
    localparam int ID_W          = $clog2(N_MASTERS_DEF);
    localparam int CNT_W         = $clog2(RD_DEPTH_DEF + 1);
    localparam int RR_MAX        = 32;

    // First set bit at or after ptr, wrapping at n; -1 when nothing is requesting.
    function automatic int rr_pick(logic [RR_MAX-1:0] req, int ptr, int n);
        int idx;
        rr_pick = -1;
        for (int k = RR_MAX - 1; k >= 0; k--) begin
            idx = 0;
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (req[idx]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/cross_bar_id_fifo.sv
// cross_bar_id_fifo: in-order FIFO of master IDs for reads accepted by one slave.
// Simultaneous push and pop are both performed.
module cross_bar_id_fifo
    import cross_bar_nxm_pkg::*;
#(
    parameter int ID_BITS  = ID_W,
    parameter int DEPTH    = RD_DEPTH_DEF,
    parameter int CNT_BITS = CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ID_BITS-1:0] din,
    input  logic               pop,
    output logic [ID_BITS-1:0] dout,
    output logic               full,
    output logic               empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][ID_BITS-1:0] mem;
    logic [PW-1:0]                 wr_ptr;
    logic [PW-1:0]                 rd_ptr;
    logic [CNT_BITS-1:0]           count;

    function automatic logic [PW-1:0] next_ptr(logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CNT_BITS'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/cross_bar_nxm.sv
// cross_bar_nxm: N-master x M-slave crossbar, per-slave arbiter, split-phase in-order reads.
// Define CROSS_BAR_FIXED_PRIO_EN for fixed-priority arbiters (no RR pointers built).
module cross_bar_nxm
    import cross_bar_nxm_pkg::*;
#(
    parameter int N_MASTERS = N_MASTERS_DEF,
    parameter int N_SLAVES  = N_SLAVES_DEF,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_DEPTH  = RD_DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_MASTERS-1:0]             m_req,
    input  logic [N_MASTERS-1:0][ADDR_W-1:0] m_addr,
    input  logic [N_MASTERS-1:0]             m_cmd,
    input  logic [N_MASTERS-1:0][DATA_W-1:0] m_wdata,
    output logic [N_MASTERS-1:0]             m_ack,
    output logic [N_MASTERS-1:0]             m_resp,
    output logic [N_MASTERS-1:0][DATA_W-1:0] m_rdata,
    output logic [N_SLAVES-1:0]              s_req,
    output logic [N_SLAVES-1:0][ADDR_W-1:0]  s_addr,
    output logic [N_SLAVES-1:0]              s_cmd,
    output logic [N_SLAVES-1:0][DATA_W-1:0]  s_wdata,
    input  logic [N_SLAVES-1:0]              s_ack,
    input  logic [N_SLAVES-1:0]              s_resp,
    input  logic [N_SLAVES-1:0][DATA_W-1:0]  s_rdata,
    output logic [N_SLAVES-1:0]              err_orphan
);
    localparam int SEL_BITS = $clog2(N_SLAVES);
    localparam int ID_BITS  = $clog2(N_MASTERS);
    localparam int CNT_BITS = $clog2(RD_DEPTH + 1);

    logic [N_MASTERS-1:0]                req_live;
    logic [N_MASTERS-1:0][SEL_BITS-1:0]  m_sel;
    logic [N_MASTERS-1:0][CNT_BITS-1:0]  rd_cnt;
    logic [N_MASTERS-1:0][SEL_BITS-1:0]  rd_slave;
    logic [N_MASTERS-1:0][SEL_BITS-1:0]  rd_slave_nxt;
    logic [N_MASTERS-1:0]                rd_inc;
    logic [N_MASTERS-1:0]                rd_dec;
    logic [N_SLAVES-1:0]                 cur_vld;
    logic [N_SLAVES-1:0][ID_BITS-1:0]    cur_id;
    logic [N_SLAVES-1:0]                 push;
    logic [N_SLAVES-1:0]                 pop;
    logic [N_SLAVES-1:0]                 fifo_full;
    logic [N_SLAVES-1:0]                 fifo_empty;
    logic [N_SLAVES-1:0][ID_BITS-1:0]    fifo_dout;

    // Requests are masked while reset is asserted so the forwarded slave side goes quiet at once.
    assign req_live = m_req & {N_MASTERS{rst_n}};

    always_comb begin
        m_sel = '0;
        for (int i = 0; i < N_MASTERS; i++) m_sel[i] = m_addr[i][ADDR_W-1 -: SEL_BITS];
    end

    for (genvar j = 0; j < N_SLAVES; j++) begin : g_slave
        logic                 locked;
        logic [ID_BITS-1:0]   owner;
        logic [ID_BITS-1:0]   ptr;
        logic [N_MASTERS-1:0] elig;
        logic                 vld;
        logic [ID_BITS-1:0]   id;
        int                   pick;

        always_comb begin
            elig = '0;
            for (int i = 0; i < N_MASTERS; i++) begin
                if (req_live[i] && m_sel[i] == SEL_BITS'(j)) begin
                    if (cmd_e'(m_cmd[i]) == CMD_WR) elig[i] = 1'b1;
                    else elig[i] = !fifo_full[j] &&
                                   (rd_cnt[i] == '0 || rd_slave[i] == SEL_BITS'(j));
                end
            end
        end

        always_comb begin
            pick = rr_pick(RR_MAX'(elig), int'(ptr), N_MASTERS);
            vld  = 1'b0;
            id   = '0;
            if (locked && req_live[owner]) begin
                vld = 1'b1;
                id  = owner;
            end else if (pick >= 0) begin
                vld = 1'b1;
                id  = ID_BITS'(pick);
            end
        end

        // A grant that is not acked is held for the same master until ack or request drop.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                locked <= 1'b0;
                owner  <= '0;
            end else begin
                locked <= vld && !s_ack[j];
                owner  <= id;
            end
        end

`ifdef CROSS_BAR_FIXED_PRIO_EN
        assign ptr = '0;
`else
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                 ptr <= '0;
            else if (vld && s_ack[j])   ptr <= (id == ID_BITS'(N_MASTERS - 1)) ? '0 : id + 1'b1;
        end
`endif

        assign cur_vld[j] = vld;
        assign cur_id[j]  = id;
        assign push[j]    = vld && s_ack[j] && (cmd_e'(m_cmd[id]) == CMD_RD);
        assign pop[j]     = s_resp[j] && !fifo_empty[j];
        assign s_req[j]   = vld;
        assign s_addr[j]  = vld ? m_addr[id]  : '0;
        assign s_cmd[j]   = vld ? m_cmd[id]   : 1'b0;
        assign s_wdata[j] = vld ? m_wdata[id] : '0;

        cross_bar_id_fifo #(
            .ID_BITS  (ID_BITS),
            .DEPTH    (RD_DEPTH),
            .CNT_BITS (CNT_BITS)
        ) u_id_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[j]),
            .din   (id),
            .pop   (pop[j]),
            .dout  (fifo_dout[j]),
            .full  (fifo_full[j]),
            .empty (fifo_empty[j])
        );
    end

    always_comb begin
        m_ack        = '0;
        m_resp       = '0;
        m_rdata      = '0;
        rd_inc       = '0;
        rd_dec       = '0;
        rd_slave_nxt = rd_slave;
        for (int j = 0; j < N_SLAVES; j++) begin
            if (cur_vld[j] && s_ack[j]) m_ack[cur_id[j]] = 1'b1;
            if (push[j]) begin
                rd_inc[cur_id[j]]       = 1'b1;
                rd_slave_nxt[cur_id[j]] = SEL_BITS'(j);
            end
            if (pop[j]) begin
                m_resp[fifo_dout[j]]  = 1'b1;
                m_rdata[fifo_dout[j]] = s_rdata[j];
                rd_dec[fifo_dout[j]]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt     <= '0;
            rd_slave   <= '0;
            err_orphan <= '0;
        end else begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (rd_inc[i] && !rd_dec[i])      rd_cnt[i] <= rd_cnt[i] + 1'b1;
                else if (rd_dec[i] && !rd_inc[i]) rd_cnt[i] <= rd_cnt[i] - 1'b1;
            end
            rd_slave   <= rd_slave_nxt;
            err_orphan <= s_resp & fifo_empty;
        end
    end

endmodule
